// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator (csb/sck/mosi out, miso in).
// One DATA_W-bit frame is shifted per accepted start. When last=0, csb
// is kept low after the frame (HELD) so several frames form one command.
// sck is produced from clk with CLK_DIV clk cycles per half-period.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   start, last    frame request (taken when ready=1); last=1 releases csb
//   tx_data        frame to transmit, sampled with start
//   ready, busy    start can be accepted / frame or csb gap in progress
//   done, rx_data  one-cycle completion pulse; received frame
//   csb, sck, mosi serial outputs (csb active low, sck idle low)
//   miso           serial input
//
// Build option: define SPI_CTRL_LSB_FIRST_EN to shift LSB first
// (default is MSB first, matching the subnode).
module spi_controller #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              last,
    input  logic [DATA_W-1:0] tx_data,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              csb,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP, HELD
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              last_q;
    logic              mosi_q;
    logic              done_q;
    logic [DATA_W-1:0] rx_q;

    logic phase_end;
    logic accept;
    logic bit_final;
    logic sample;

    assign phase_end = (cnt == CNT_W'(CLK_DIV - 1));
    assign bit_final = (bit_cnt == BIT_W'(DATA_W - 1));
    assign accept    = start && ready;
    assign sample    = (state == SCK_HI) && phase_end;

    // Bus outputs decode straight from the state register, so the async
    // reset of the state forces csb=1 / sck=0 with no clock edge.
    assign ready   = (state == IDLE) || (state == HELD);
    assign busy    = !ready;
    assign sck     = (state == SCK_HI);
    assign csb     = (state == IDLE) || (state == GAP);
    assign mosi    = mosi_q;
    assign done    = done_q;
    assign rx_data = rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, HELD: if (accept)    state_next = SETUP;
            SETUP:      if (phase_end) state_next = SCK_HI;
            SCK_HI:     if (phase_end) state_next = bit_final ? HOLD : SCK_LO;
            SCK_LO:     if (phase_end) state_next = SCK_HI;
            HOLD:       if (phase_end) state_next = last_q ? GAP : HELD;
            GAP:        if (phase_end) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            last_q   <= 1'b0;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
            rx_q     <= '0;
        end else begin
            // Half-period counter wraps at every phase boundary and is
            // parked at zero while waiting, so SETUP always starts fresh.
            if (state == IDLE || state == HELD || phase_end)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (accept) begin
                tx_shift <= tx_data;
                last_q   <= last;
                bit_cnt  <= '0;
`ifdef SPI_CTRL_LSB_FIRST_EN
                mosi_q   <= tx_data[0];
`else
                mosi_q   <= tx_data[DATA_W-1];
`endif
            end

            // miso is captured late in the high phase to cover the
            // subnode's synchronizer delay; mosi moves on as sck falls.
            if (sample) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
`ifdef SPI_CTRL_LSB_FIRST_EN
                rx_shift <= {miso, rx_shift[DATA_W-1:1]};
                if (!bit_final) begin
                    tx_shift <= tx_shift >> 1;
                    mosi_q   <= tx_shift[1];
                end
`else
                rx_shift <= {rx_shift[DATA_W-2:0], miso};
                if (!bit_final) begin
                    tx_shift <= tx_shift << 1;
                    mosi_q   <= tx_shift[DATA_W-2];
                end
`endif
            end

            done_q <= (state == HOLD) && phase_end;
            if ((state == HOLD) && phase_end)
                rx_q <= rx_shift;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed self-checking bench for spi_controller.
// Cycle n counts from the edge that accepts start (cycle 1 follows it).
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       last = 1'b0;
    logic [7:0] tx_data = '0;
    logic       ready, busy, done, csb, sck, mosi, miso;
    logic [7:0] rx_data;
    logic       loop_en = 1'b1;
    logic       miso_val = 1'b0;

    logic        start16 = 1'b0;
    logic        last16 = 1'b0;
    logic [15:0] tx16 = '0;
    logic        ready16, busy16, done16, csb16, sck16, mosi16;
    logic        miso16 = 1'b1;
    logic [15:0] rx16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_val;

    spi_controller #(.DATA_W(8), .CLK_DIV(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last(last),
        .tx_data(tx_data), .ready(ready), .busy(busy), .done(done),
        .rx_data(rx_data), .csb(csb), .sck(sck), .mosi(mosi), .miso(miso)
    );

    spi_controller #(.DATA_W(16), .CLK_DIV(4), .CNT_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .last(last16),
        .tx_data(tx16), .ready(ready16), .busy(busy16), .done(done16),
        .rx_data(rx16), .csb(csb16), .sck(sck16), .mosi(mosi16), .miso(miso16)
    );

    // observation results
    int          rises, done_cnt, first_done, last_done, ready_cyc, csb_rise;
    logic [31:0] mosi_seq;
    logic [7:0]  rx_first, rx_last;
    logic        mosi_one, first_mosi, busy1;
    // injection control
    int          inj_cyc;
    logic [7:0]  inj_data;
    logic        inj_last;
    logic        chain_en;
    int          chain_delay;

    task automatic kick(input logic [7:0] d, input logic l);
        @(negedge clk);
        start = 1'b1; tx_data = d; last = l;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic observe(input int ncyc);
        logic prev_sck;
        rises = 0; done_cnt = 0; first_done = -1; last_done = -1;
        ready_cyc = -1; csb_rise = -1; mosi_seq = '0; mosi_one = 1'b0;
        first_mosi = 1'b0; busy1 = 1'b0; rx_first = '0; rx_last = '0;
        prev_sck = sck;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (c == 1) busy1 = busy;
            if (sck && !prev_sck) begin
                if (rises == 0) first_mosi = mosi;
                rises++;
                mosi_seq = {mosi_seq[30:0], mosi};
            end
            prev_sck = sck;
            if (mosi) mosi_one = 1'b1;
            if (csb && csb_rise < 0) csb_rise = c;
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin first_done = c; rx_first = rx_data; end
                last_done = c;
                rx_last = rx_data;
                ready_cyc = -1;
                if (chain_en && done_cnt == 1) inj_cyc = c + chain_delay;
            end else if (ready && ready_cyc < 0 && last_done > 0) begin
                ready_cyc = c;
            end
            if (c == inj_cyc) begin
                start = 1'b1; tx_data = inj_data; last = inj_last;
            end
        end
        start = 1'b0;
    endtask

    task automatic clear_inj();
        inj_cyc = -1; chain_en = 1'b0; chain_delay = 0;
        inj_data = '0; inj_last = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (csb !== 1'b1) begin errors++; $display("FAIL rst_csb got %b want 1", csb); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", mosi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
        checks++; if (ready !== 1'b1 || rx_data !== 8'h00) begin errors++; $display("FAIL rst_ready_rx got %b %h want 1 00", ready, rx_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        kick(8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (sck !== 1'b1 || csb !== 1'b0) begin errors++; $display("FAIL mid_frame sck/csb got %b/%b want 1/0", sck, csb); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (csb !== 1'b1 || sck !== 1'b0) begin errors++; $display("FAIL async_abort csb/sck got %b/%b want 1/0", csb, sck); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inj();
        observe(80);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        checks++; if (ready !== 1'b1 || rx_data !== 8'h00 || csb !== 1'b1) begin errors++; $display("FAIL after_abort ready/rx/csb got %b/%h/%b want 1/00/1", ready, rx_data, csb); end
    endtask

    task automatic test_single_frame();
        loop_en = 1'b1;
        clear_inj();
        kick(8'hA5, 1'b1);
        observe(90);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b want 1", busy1); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL single_rises got %0d want 8", rises); end
        checks++; if (mosi_seq[7:0] !== 8'hA5) begin errors++; $display("FAIL single_mosi got %h want a5", mosi_seq[7:0]); end
        checks++; if (first_done !== 69 || done_cnt !== 1) begin errors++; $display("FAIL single_done got cyc %0d cnt %0d want 69 1", first_done, done_cnt); end
        checks++; if (rx_last !== 8'hA5) begin errors++; $display("FAIL single_rx got %h want a5", rx_last); end
        checks++; if (csb_rise !== 69) begin errors++; $display("FAIL single_csb_rise got %0d want 69", csb_rise); end
        checks++; if (ready_cyc !== 73) begin errors++; $display("FAIL single_ready got %0d want 73", ready_cyc); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_hold got %h want a5", rx_data); end
    endtask

    task automatic test_busy_reject();
        loop_en = 1'b1;
        clear_inj();
        inj_cyc = 10; inj_data = 8'h3C; inj_last = 1'b1;
        kick(8'h96, 1'b1);
        observe(150);
        checks++; if (rises !== 8) begin errors++; $display("FAIL reject_rises got %0d want 8", rises); end
        checks++; if (mosi_seq[7:0] !== 8'h96) begin errors++; $display("FAIL reject_mosi got %h want 96", mosi_seq[7:0]); end
        checks++; if (done_cnt !== 1 || rx_last !== 8'h96) begin errors++; $display("FAIL reject_done got cnt %0d rx %h want 1 96", done_cnt, rx_last); end
    endtask

    task automatic test_held_chain();
        loop_en = 1'b1;
        clear_inj();
        chain_en = 1'b1; chain_delay = 5; inj_data = 8'hFF; inj_last = 1'b1;
        kick(8'h01, 1'b0);
        observe(170);
        checks++; if (rises !== 16) begin errors++; $display("FAIL chain_rises got %0d want 16", rises); end
`ifdef SPI_CTRL_LSB_FIRST_EN
        checks++; if (mosi_seq[15:0] !== 16'h80FF) begin errors++; $display("FAIL chain_mosi got %h want 80ff", mosi_seq[15:0]); end
`else
        checks++; if (mosi_seq[15:0] !== 16'h01FF) begin errors++; $display("FAIL chain_mosi got %h want 01ff", mosi_seq[15:0]); end
`endif
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL chain_done_cnt got %0d want 2", done_cnt); end
        checks++; if (first_done !== 69 || last_done !== 143) begin errors++; $display("FAIL chain_done_cyc got %0d/%0d want 69/143", first_done, last_done); end
        checks++; if (rx_first !== 8'h01 || rx_last !== 8'hFF) begin errors++; $display("FAIL chain_rx got %h/%h want 01/ff", rx_first, rx_last); end
        checks++; if (csb_rise !== 143) begin errors++; $display("FAIL chain_csb_rise got %0d want 143", csb_rise); end
        checks++; if (ready_cyc !== 147) begin errors++; $display("FAIL chain_ready got %0d want 147", ready_cyc); end
    endtask

    task automatic test_const_miso();
        int r16, d16;
        logic p16, m16;
        loop_en = 1'b0; miso_val = 1'b1;
        clear_inj();
        kick(8'h00, 1'b1);
        observe(80);
        checks++; if (rx_last !== 8'hFF || done_cnt !== 1) begin errors++; $display("FAIL const_rx got %h cnt %0d want ff 1", rx_last, done_cnt); end
        checks++; if (mosi_one !== 1'b0) begin errors++; $display("FAIL const_mosi got %b want 0", mosi_one); end
        loop_en = 1'b1;
        // 16-bit instance
        @(negedge clk);
        start16 = 1'b1; tx16 = 16'h0000; last16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        r16 = 0; d16 = -1; p16 = sck16; m16 = 1'b0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (sck16 && !p16) r16++;
            p16 = sck16;
            if (mosi16) m16 = 1'b1;
            if (done16 && d16 < 0) d16 = c;
        end
        checks++; if (r16 !== 16) begin errors++; $display("FAIL w16_rises got %0d want 16", r16); end
        checks++; if (d16 !== 133) begin errors++; $display("FAIL w16_done got %0d want 133", d16); end
        checks++; if (rx16 !== 16'hFFFF || m16 !== 1'b0) begin errors++; $display("FAIL w16_rx got %h mosi1 %b want ffff 0", rx16, m16); end
    endtask

    task automatic test_bit_order();
        loop_en = 1'b1;
        clear_inj();
        kick(8'h01, 1'b1);
        observe(80);
`ifdef SPI_CTRL_LSB_FIRST_EN
        checks++; if (first_mosi !== 1'b1 || mosi_seq[7:0] !== 8'h80) begin errors++; $display("FAIL order_mosi got %b %h want 1 80", first_mosi, mosi_seq[7:0]); end
`else
        checks++; if (first_mosi !== 1'b0 || mosi_seq[7:0] !== 8'h01) begin errors++; $display("FAIL order_mosi got %b %h want 0 01", first_mosi, mosi_seq[7:0]); end
`endif
        checks++; if (rx_last !== 8'h01) begin errors++; $display("FAIL order_rx got %h want 01", rx_last); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_busy_reject();
        test_held_chain();
        test_const_miso();
        test_bit_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
